// File: rtl/tff_sb_pkg.sv
// Shared definitions for the T flip-flop scoreboard.
//   sb_state_t   : scoreboard FSM encoding, also driven out on the state port
//   next_model() : one clock edge of the reference T flip-flop
//                  (active-low reset > set > toggle > hold)
package tff_sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } sb_state_t;

  function automatic logic next_model(input logic m, input logic rst_n,
                                      input logic set, input logic t);
    logic r;
    if (!rst_n) begin
      r = 1'b0;
    end else if (set) begin
      r = 1'b1;
    end else if (t) begin
      r = ~m;
    end else begin
      r = m;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the scoreboard statistics.
//   clk : clock
//   clr : synchronous clear, wins over inc
//   inc : count one event this edge
//   cnt : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tff_scoreboard.sv
// Self-checking monitor for a T flip-flop. It samples the same t/set/reset
// stimulus the flip-flop sees, runs a cycle-accurate reference bit, and
// compares it against the flip-flop's q/qbar each clock.
//   clk, reset        : clock, synchronous active-high scoreboard reset
//   enable            : 1 arms checking, 0 returns to IDLE (not from FAIL)
//   dut_reset/set/t   : stimulus as driven to the flip-flop
//   dut_q, dut_qbar   : flip-flop outputs under test
//   mismatch          : registered one-cycle pulse for a failed compare
//   error             : sticky, set on the first mismatch
//   err_count, check_count, toggle_count : saturating statistics
//   first_err_cycle   : check_count value (including that compare) at the
//                       first mismatch
//   state             : 0 IDLE, 1 SYNC, 2 CHECK, 3 FAIL
module tff_scoreboard
  import tff_sb_pkg::*;
#(
  parameter int CW          = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          dut_reset,
  input  logic          dut_set,
  input  logic          dut_t,
  input  logic          dut_q,
  input  logic          dut_qbar,
  output logic          mismatch,
  output logic          error,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] check_count,
  output logic [CW-1:0] toggle_count,
  output logic [CW-1:0] first_err_cycle,
  output logic [1:0]    state
);

  sb_state_t     state_q, state_d;
  logic          model_q, model_d;
  logic          valid_q, valid_d;
  logic          mismatch_q, error_q;
  logic [CW-1:0] first_q, first_d;
  logic          compare, fail, toggle_hit;
  logic [CW-1:0] check_next;

  // A compare is only meaningful once the model has been aligned to the
  // flip-flop for a full cycle in CHECK; valid_q carries that qualification.
  assign compare    = (state_q == ST_CHECK) && valid_q;
  assign fail       = compare && ((dut_q != model_q) || (dut_qbar == dut_q));
  assign toggle_hit = (state_q == ST_CHECK) && dut_reset && !dut_set && dut_t;

  // check_count as it will read after this compare is counted.
  assign check_next = (check_count == '1) ? check_count : check_count + CW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable)        state_d = ST_IDLE;
        else if (!dut_reset) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // A failing compare still counts when enable drops on the same edge.
        if (fail && STOP_ON_ERR) state_d = ST_FAIL;
        else if (!enable)        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    model_d = model_q;
    if ((state_q == ST_SYNC) || (state_q == ST_CHECK)) begin
      model_d = next_model(model_q, dut_reset, dut_set, dut_t);
    end
    valid_d = (state_q == ST_CHECK) && (state_d == ST_CHECK);
    first_d = first_q;
    if (fail && !error_q) begin
      first_d = check_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      model_q    <= 1'b0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      model_q    <= model_d;
      valid_q    <= valid_d;
      mismatch_q <= fail;
      error_q    <= error_q | fail;
      first_q    <= first_d;
    end
  end

  // In FAIL no compares happen and toggle_hit is low, so all three freeze.
  sat_counter #(.CW(CW)) u_check_cnt (
    .clk (clk),
    .clr (reset),
    .inc (compare),
    .cnt (check_count)
  );

  sat_counter #(.CW(CW)) u_err_cnt (
    .clk (clk),
    .clr (reset),
    .inc (fail),
    .cnt (err_count)
  );

  sat_counter #(.CW(CW)) u_toggle_cnt (
    .clk (clk),
    .clr (reset),
    .inc (toggle_hit),
    .cnt (toggle_count)
  );

  assign mismatch        = mismatch_q;
  assign error           = error_q;
  assign first_err_cycle = first_q;
  assign state           = state_q;

endmodule

// File: tb/tb_tff_scoreboard.sv
// Bench for tff_scoreboard. Three instances share one stimulus stream:
//   u0: CW=16 keep checking, u1: CW=16 stop on error, u2: CW=4 keep checking.
// A behavioural T flip-flop with selectable faults drives dut_q/dut_qbar.
module tb_tff_scoreboard;

  logic clk;
  logic reset, enable, dut_reset, dut_set, dut_t;
  logic dut_q, dut_qbar;
  logic good_q = 1'b0;
  int   fault;  // 0 none, 1 q stuck at 0, 2 q inverted, 3 qbar equals q

  logic        mis0, mis1, mis2, err0, err1, err2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] ec0, cc0, tc0, fe0, ec1, cc1, tc1, fe1;
  logic [3:0]  ec2, cc2, tc2, fe2;

  int checks = 0;
  int failures = 0;
  int stepn = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flip-flop under observation
  always_ff @(posedge clk) begin
    if (!dut_reset)   good_q <= 1'b0;
    else if (dut_set) good_q <= 1'b1;
    else if (dut_t)   good_q <= ~good_q;
  end

  assign dut_q    = (fault == 1) ? 1'b0 : (fault == 2) ? ~good_q : good_q;
  assign dut_qbar = (fault == 3) ? dut_q : ~dut_q;

  tff_scoreboard #(.CW(16), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .dut_reset(dut_reset),
    .dut_set(dut_set), .dut_t(dut_t), .dut_q(dut_q), .dut_qbar(dut_qbar),
    .mismatch(mis0), .error(err0), .err_count(ec0), .check_count(cc0),
    .toggle_count(tc0), .first_err_cycle(fe0), .state(st0));

  tff_scoreboard #(.CW(16), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .dut_reset(dut_reset),
    .dut_set(dut_set), .dut_t(dut_t), .dut_q(dut_q), .dut_qbar(dut_qbar),
    .mismatch(mis1), .error(err1), .err_count(ec1), .check_count(cc1),
    .toggle_count(tc1), .first_err_cycle(fe1), .state(st1));

  tff_scoreboard #(.CW(4), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .dut_reset(dut_reset),
    .dut_set(dut_set), .dut_t(dut_t), .dut_q(dut_q), .dut_qbar(dut_qbar),
    .mismatch(mis2), .error(err2), .err_count(ec2), .check_count(cc2),
    .toggle_count(tc2), .first_err_cycle(fe2), .state(st2));

  // ---------------- reference model (per instance) ----------------
  // Phase numbers follow the state port values: 0 idle, 1 sync, 2 check, 3 fail.
  int  m_ph[3], m_age[3], m_bit[3], m_mis[3], m_err[3];
  int  m_ec[3], m_chk[3], m_tog[3], m_first[3];
  int  m_max[3]  = '{65535, 65535, 15};
  int  m_stop[3] = '{0, 1, 0};
  int  a_st[3], a_mis[3], a_err[3], a_ec[3], a_chk[3], a_tog[3], a_first[3];

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic model_edge(input int i, input int rst, input int en, input int rn,
                            input int set, input int t, input int q, input int qb);
    bit cmp, bad;
    if (rst != 0) begin
      m_ph[i] = 0; m_age[i] = 0; m_bit[i] = 0; m_mis[i] = 0; m_err[i] = 0;
      m_ec[i] = 0; m_chk[i] = 0; m_tog[i] = 0; m_first[i] = 0;
      return;
    end
    // compare uses the model value left by the previous edge
    cmp = (m_ph[i] == 2) && (m_age[i] >= 1);
    bad = cmp && ((q != m_bit[i]) || (qb == q));
    if (cmp) m_chk[i] = sat_inc(m_chk[i], m_max[i]);
    m_mis[i] = bad ? 1 : 0;
    if (bad) begin
      m_ec[i] = sat_inc(m_ec[i], m_max[i]);
      if (m_err[i] == 0) m_first[i] = m_chk[i];
      m_err[i] = 1;
    end
    if (m_ph[i] == 2 && rn != 0 && set == 0 && t != 0) m_tog[i] = sat_inc(m_tog[i], m_max[i]);
    if (m_ph[i] == 1 || m_ph[i] == 2) begin
      if (rn == 0)       m_bit[i] = 0;
      else if (set != 0) m_bit[i] = 1;
      else if (t != 0)   m_bit[i] = 1 - m_bit[i];
    end
    case (m_ph[i])
      0: begin
        m_age[i] = 0;
        if (en != 0) m_ph[i] = 1;
      end
      1: begin
        m_age[i] = 0;
        if (en == 0)      m_ph[i] = 0;
        else if (rn == 0) m_ph[i] = 2;
      end
      2: begin
        if (bad && m_stop[i] != 0) begin m_ph[i] = 3; m_age[i] = 0; end
        else if (en == 0)          begin m_ph[i] = 0; m_age[i] = 0; end
        else                       m_age[i] = m_age[i] + 1;
      end
      default: m_ph[i] = 3;
    endcase
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL step%0d %s actual=%0d required=%0d", stepn, name, act, exp);
    end
  endtask

  task automatic snapshot();
    a_st[0] = int'(st0); a_mis[0] = int'(mis0); a_err[0] = int'(err0);
    a_ec[0] = int'(ec0); a_chk[0] = int'(cc0); a_tog[0] = int'(tc0); a_first[0] = int'(fe0);
    a_st[1] = int'(st1); a_mis[1] = int'(mis1); a_err[1] = int'(err1);
    a_ec[1] = int'(ec1); a_chk[1] = int'(cc1); a_tog[1] = int'(tc1); a_first[1] = int'(fe1);
    a_st[2] = int'(st2); a_mis[2] = int'(mis2); a_err[2] = int'(err2);
    a_ec[2] = int'(ec2); a_chk[2] = int'(cc2); a_tog[2] = int'(tc2); a_first[2] = int'(fe2);
  endtask

  task automatic check_inst(input int i, input int st, input int mis, input int err,
                            input int ec, input int chk, input int tog, input int first,
                            input string tag);
    check($sformatf("%s.u%0d.state", tag, i), a_st[i], st);
    check($sformatf("%s.u%0d.mismatch", tag, i), a_mis[i], mis);
    check($sformatf("%s.u%0d.error", tag, i), a_err[i], err);
    check($sformatf("%s.u%0d.err_count", tag, i), a_ec[i], ec);
    check($sformatf("%s.u%0d.check_count", tag, i), a_chk[i], chk);
    check($sformatf("%s.u%0d.toggle_count", tag, i), a_tog[i], tog);
    check($sformatf("%s.u%0d.first_err_cycle", tag, i), a_first[i], first);
  endtask

  // driver: one clock of stimulus, then model update and compare of all instances
  task automatic step(input int rst, input int en, input int rn, input int set,
                      input int t, input int flt);
    int q_s, qb_s;
    @(negedge clk);
    reset     = (rst != 0);
    enable    = (en != 0);
    dut_reset = (rn != 0);
    dut_set   = (set != 0);
    dut_t     = (t != 0);
    fault     = flt;
    #1;
    q_s  = int'(dut_q);
    qb_s = int'(dut_qbar);
    @(posedge clk);
    #1;
    stepn++;
    snapshot();
    for (int i = 0; i < 3; i++) begin
      model_edge(i, rst, en, rn, set, t, q_s, qb_s);
      check_inst(i, m_ph[i], m_mis[i], m_err[i], m_ec[i], m_chk[i], m_tog[i],
                 m_first[i], "model");
    end
  endtask

  typedef struct {
    int rst, en, rn, set, t, flt;
    int st, mis, err, ec, chk, tog, first;
  } vec_t;

  vec_t tbl[18];

  initial begin
    reset = 1'b1; enable = 1'b0; dut_reset = 1'b1; dut_set = 1'b0; dut_t = 1'b0;
    fault = 0;
    for (int i = 0; i < 3; i++) model_edge(i, 1, 0, 1, 0, 0, 0, 1);

    // rst en rn set t flt | state mis err ec chk tog first  (instance u0)
    tbl[0]  = '{1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0,  2, 0, 0, 0, 0,  0, 0};  // reset beats set
    tbl[3]  = '{0, 1, 1, 0, 1, 0,  2, 0, 0, 0, 0,  1, 0};
    tbl[4]  = '{0, 1, 1, 0, 1, 0,  2, 0, 0, 0, 1,  2, 0};  // first compare
    tbl[5]  = '{0, 1, 1, 0, 1, 0,  2, 0, 0, 0, 2,  3, 0};
    tbl[6]  = '{0, 1, 1, 0, 1, 0,  2, 0, 0, 0, 3,  4, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0,  2, 0, 0, 0, 4,  4, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 0,  2, 0, 0, 0, 5,  4, 0};  // set pulse
    tbl[9]  = '{0, 1, 1, 0, 0, 1,  2, 1, 1, 1, 6,  4, 6};  // q stuck 0
    tbl[10] = '{0, 1, 1, 0, 0, 1,  2, 1, 1, 2, 7,  4, 6};
    tbl[11] = '{0, 1, 1, 0, 0, 0,  2, 0, 1, 2, 8,  4, 6};
    tbl[12] = '{0, 0, 1, 0, 0, 0,  0, 0, 1, 2, 9,  4, 6};  // enable drop counts
    tbl[13] = '{0, 1, 1, 0, 0, 0,  1, 0, 1, 2, 9,  4, 6};
    tbl[14] = '{0, 1, 1, 0, 1, 0,  1, 0, 1, 2, 9,  4, 6};  // no compare in SYNC
    tbl[15] = '{0, 1, 0, 0, 0, 0,  2, 0, 1, 2, 9,  4, 6};
    tbl[16] = '{0, 1, 1, 0, 0, 0,  2, 0, 1, 2, 9,  4, 6};
    tbl[17] = '{0, 1, 1, 0, 0, 0,  2, 0, 1, 2, 10, 4, 6};

    for (int r = 0; r < 18; r++) begin
      step(tbl[r].rst, tbl[r].en, tbl[r].rn, tbl[r].set, tbl[r].t, tbl[r].flt);
      check_inst(0, tbl[r].st, tbl[r].mis, tbl[r].err, tbl[r].ec, tbl[r].chk,
                 tbl[r].tog, tbl[r].first, $sformatf("tbl%0d", r));
    end
    // stop-on-error instance froze at its first mismatch (row 9)
    check_inst(1, 3, 0, 1, 1, 6, 4, 6, "tbl_stop");

    // saturation: every compare fails for 20 cycles
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 1, int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)), 2);
    end
    check("sat.u2.err_count", a_ec[2], 15);
    check("sat.u2.check_count", a_chk[2], 15);
    check("sat.u2.mismatch", a_mis[2], 1);
    check("sat.u0.err_count", a_ec[0], 22);
    check("sat.u0.check_count", a_chk[0], 30);

    // reset mid-operation clears everything
    step(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) check_inst(i, 0, 0, 0, 0, 0, 0, 0, "rst");

    // stop on error with qbar forced equal to q
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 3);
    check_inst(1, 3, 1, 1, 1, 2, 0, 2, "stop_hit");
    for (int k = 0; k < 20; k++) begin
      step(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
      check_inst(1, 3, 0, 1, 1, 2, 0, 2, "frozen");
    end
    step(1, 0, 1, 0, 0, 0);
    check_inst(1, 0, 0, 0, 0, 0, 0, 0, "stop_rst");

    // randomized run against the model
    for (int k = 0; k < 600; k++) begin
      step(int'($urandom_range(0, 99) == 0), int'($urandom_range(0, 19) != 0),
           int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
